pwm_duty_sequencer: RTL

//  Sequences duty-cycle commands into the VSI PWM/dead-time leg.
//  - Accepts duty commands from the control loop over a valid/ready handshake.
//  - Applies them only on PWM period boundaries, taken from the PWM interrupt.
//  - Soft-starts from zero and slew-limits every change.
//  - Forces the bridge off on fault or disable.
//  - Drives the duty input of the PWM generator and the gate enable of the dead-time stage.

---
 rtl/pwm_duty_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_duty_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_duty_sequencer
//
// Purpose:
//   Sequences duty-cycle commands from the control loop into the VSI PWM /
//   dead-time leg. Commands are taken over a valid/ready handshake into a
//   single-entry pending register. They are applied only on PWM period
//   boundaries, which are derived from the asynchronous PWM period interrupt.
//   The block soft-starts from zero, slew-limits every change, and forces the
//   bridge off on fault or when the supervisor drops enable.
//
// Optional feature (macro PERIOD_WDT_EN):
//   When defined, a period watchdog trips the bridge if WDT_CYCLES clk cycles
//   pass in RAMP/RUN without a period edge. The trip is handled exactly like a
//   fault. When undefined, a missing period interrupt just freezes duty.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   enable        in   run request from supervisor (level)
//   fault         in   hardware fault, active-high, synchronous to clk
//   period_irq    in   PWM period interrupt, asynchronous to clk
//   cmd_valid     in   duty command valid
//   cmd_duty      in   duty command value
//   cmd_ready     out  sequencer can accept a command
//   duty          out  registered duty to PWM generator
//   gate_en       out  registered gate enable for dead-time stage
//   update_strobe out  registered one-clk pulse when duty is updated
//   state_o       out  registered state: 0=IDLE 1=RAMP 2=RUN 3=TRIP
// ---------------------------------------------------------------------------
module pwm_duty_sequencer #(
  parameter int unsigned DUTY_W     = 10,
  parameter int unsigned DUTY_MAX   = 1000,
  parameter int unsigned RAMP_STEP  = 4,
  parameter int unsigned SLEW_STEP  = 16,
  parameter int unsigned WDT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fault,
  input  logic              period_irq,
  input  logic              cmd_valid,
  input  logic [DUTY_W-1:0] cmd_duty,
  output logic              cmd_ready,
  output logic [DUTY_W-1:0] duty,
  output logic              gate_en,
  output logic              update_strobe,
  output logic [1:0]        state_o
);

  // Arithmetic width: one extra bit so sums never wrap before saturation.
  localparam int unsigned AW = DUTY_W + 1;

  localparam logic [AW-1:0]     MAX_A  = AW'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] MAX_D  = DUTY_W'(DUTY_MAX);
  localparam logic [AW-1:0]     RAMP_A = AW'(RAMP_STEP);
  localparam logic [AW-1:0]     SLEW_A = AW'(SLEW_STEP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_RUN  = 2'd2,
    ST_TRIP = 2'd3
  } state_t;

  // Saturate an extended-width value into [0, DUTY_MAX].
  function automatic logic [DUTY_W-1:0] sat_duty(input logic [AW-1:0] v);
    logic [DUTY_W-1:0] r;
    if (v > MAX_A) begin
      r = MAX_D;
    end else begin
      r = v[DUTY_W-1:0];
    end
    return r;
  endfunction

  // Soft-start step: rise by at most RAMP_STEP, never beyond the target.
  // A target below the present duty is taken directly.
  function automatic logic [DUTY_W-1:0] ramp_step(input logic [DUTY_W-1:0] cur,
                                                  input logic [DUTY_W-1:0] tgt);
    logic [AW-1:0] sum;
    logic [AW-1:0] tgt_x;
    logic [AW-1:0] res;
    sum   = {1'b0, cur} + RAMP_A;
    tgt_x = {1'b0, tgt};
    if (sum > tgt_x) begin
      res = tgt_x;
    end else begin
      res = sum;
    end
    return sat_duty(res);
  endfunction

  // Slew step: move toward the target by at most SLEW_STEP, no overshoot.
  function automatic logic [DUTY_W-1:0] slew_step(input logic [DUTY_W-1:0] cur,
                                                  input logic [DUTY_W-1:0] tgt);
    logic [AW-1:0] cur_x;
    logic [AW-1:0] tgt_x;
    logic [AW-1:0] res;
    cur_x = {1'b0, cur};
    tgt_x = {1'b0, tgt};
    if (tgt_x > cur_x) begin
      if ((tgt_x - cur_x) > SLEW_A) begin
        res = cur_x + SLEW_A;
      end else begin
        res = tgt_x;
      end
    end else begin
      if ((cur_x - tgt_x) > SLEW_A) begin
        res = cur_x - SLEW_A;
      end else begin
        res = tgt_x;
      end
    end
    return sat_duty(res);
  endfunction

  // Registers
  logic              irq_meta_r;
  logic              irq_sync_r;
  logic              irq_prev_r;
  state_t            state_r;
  logic [DUTY_W-1:0] duty_r;
  logic              gate_en_r;
  logic              strobe_r;
  logic [DUTY_W-1:0] target_r;
  logic [DUTY_W-1:0] pend_r;
  logic              pend_vld_r;

  // Next-state values
  state_t            state_n;
  logic [DUTY_W-1:0] duty_n;
  logic              gate_en_n;
  logic              strobe_n;
  logic [DUTY_W-1:0] target_n;
  logic [DUTY_W-1:0] pend_n;
  logic              pend_vld_n;

  logic              tev_s;
  logic              accept_s;
  logic              trip_s;
  logic              wdt_trip_s;
  logic [DUTY_W-1:0] cmd_clamped_s;
  logic [DUTY_W-1:0] tgt_eff_s;

  // Period interrupt synchronizer plus edge-detect history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_meta_r <= 1'b0;
      irq_sync_r <= 1'b0;
      irq_prev_r <= 1'b0;
    end else begin
      irq_meta_r <= period_irq;
      irq_sync_r <= irq_meta_r;
      irq_prev_r <= irq_sync_r;
    end
  end

  // Tick is high for one clk after the synchronized rising edge, so the
  // registered duty update lands on the third clk edge after the irq rises.
  assign tev_s = irq_sync_r & ~irq_prev_r;

  assign cmd_ready     = ~pend_vld_r & (state_r != ST_TRIP);
  assign accept_s      = cmd_valid & cmd_ready;
  assign cmd_clamped_s = sat_duty({1'b0, cmd_duty});

  // A pending command that transfers on this tick is already the target the
  // update works toward, so the first RAMP tick moves off zero immediately.
  assign tgt_eff_s = (tev_s && pend_vld_r) ? pend_r : target_r;

`ifdef PERIOD_WDT_EN
  localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt_r;
  logic             wdt_active_s;

  assign wdt_active_s = (state_r == ST_RAMP) || (state_r == ST_RUN);
  assign wdt_trip_s   = wdt_active_s && !tev_s && (wdt_cnt_r >= WDT_LAST);

  // Watchdog counter: cleared by each tick and outside RAMP/RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt_r <= '0;
    end else if (!wdt_active_s || tev_s) begin
      wdt_cnt_r <= '0;
    end else if (wdt_cnt_r < WDT_LAST) begin
      wdt_cnt_r <= wdt_cnt_r + WDT_W'(1);
    end else begin
      wdt_cnt_r <= wdt_cnt_r;
    end
  end
`else
  logic unused_wdt_s;
  assign unused_wdt_s = (WDT_CYCLES == 32'd0);
  assign wdt_trip_s   = 1'b0;
`endif

  assign trip_s = fault | wdt_trip_s;

  // Sequencer state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      duty_r     <= '0;
      gate_en_r  <= 1'b0;
      strobe_r   <= 1'b0;
      target_r   <= '0;
      pend_r     <= '0;
      pend_vld_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      duty_r     <= duty_n;
      gate_en_r  <= gate_en_n;
      strobe_r   <= strobe_n;
      target_r   <= target_n;
      pend_r     <= pend_n;
      pend_vld_r <= pend_vld_n;
    end
  end

  // Next-state, command path and duty update (fault > !enable > tick).
  always_comb begin
    state_n    = state_r;
    duty_n     = duty_r;
    gate_en_n  = gate_en_r;
    strobe_n   = 1'b0;
    target_n   = target_r;
    pend_n     = pend_r;
    pend_vld_n = pend_vld_r;

    if (accept_s) begin
      pend_n     = cmd_clamped_s;
      pend_vld_n = 1'b1;
    end else begin
      pend_n     = pend_r;
    end

    case (state_r)
      ST_IDLE: begin
        duty_n    = '0;
        gate_en_n = 1'b0;
        if (trip_s) begin
          state_n    = ST_TRIP;
          target_n   = '0;
          pend_vld_n = 1'b0;
        end else if (enable) begin
          state_n   = ST_RAMP;
          gate_en_n = 1'b1;
        end else begin
          state_n   = ST_IDLE;
        end
      end

      ST_RAMP, ST_RUN: begin
        if (trip_s) begin
          state_n    = ST_TRIP;
          duty_n     = '0;
          gate_en_n  = 1'b0;
          target_n   = '0;
          pend_vld_n = 1'b0;
        end else if (!enable) begin
          // Pending command survives a disable; target does not.
          state_n   = ST_IDLE;
          duty_n    = '0;
          gate_en_n = 1'b0;
          target_n  = '0;
        end else if (tev_s) begin
          gate_en_n = 1'b1;
          strobe_n  = 1'b1;
          target_n  = tgt_eff_s;
          if (pend_vld_r) begin
            // cmd_ready is low while pending, so no accept collides here.
            pend_vld_n = 1'b0;
          end else begin
            pend_vld_n = pend_vld_n;
          end
          if (state_r == ST_RAMP) begin
            duty_n = ramp_step(duty_r, tgt_eff_s);
            if (ramp_step(duty_r, tgt_eff_s) == tgt_eff_s) begin
              state_n = ST_RUN;
            end else begin
              state_n = ST_RAMP;
            end
          end else begin
            duty_n  = slew_step(duty_r, tgt_eff_s);
            state_n = ST_RUN;
          end
        end else begin
          gate_en_n = 1'b1;
        end
      end

      ST_TRIP: begin
        duty_n     = '0;
        gate_en_n  = 1'b0;
        target_n   = '0;
        pend_vld_n = 1'b0;
        if (!fault && !enable) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_TRIP;
        end
      end

      default: begin
        state_n    = ST_TRIP;
        duty_n     = '0;
        gate_en_n  = 1'b0;
        target_n   = '0;
        pend_vld_n = 1'b0;
      end
    endcase
  end

  assign duty          = duty_r;
  assign gate_en       = gate_en_r;
  assign update_strobe = strobe_r;
  assign state_o       = state_r;

endmodule
